gray_count_decoder: RTL



---
 rtl/gray_count_decoder_if.sv | 22 ++
 rtl/gray_count_decoder.sv | 95 +++++++++
 2 files changed

// File: rtl/gray_count_decoder_if.sv
// gray_count_decoder_if: sample/result bundle for the Gray count decoder
//   en, gray_in, clear_err           : driven by the sampling side (master)
//   bin_out, bin_valid, step_err,
//   wrap, locked, err_cnt            : driven by the decoder (slave)
interface gray_count_decoder_if #(
   parameter int W     = 4,
   parameter int ERR_W = 8
);
   logic             en;
   logic [W-1:0]     gray_in;
   logic             clear_err;
   logic [W-1:0]     bin_out;
   logic             bin_valid;
   logic             step_err;
   logic             wrap;
   logic             locked;
   logic [ERR_W-1:0] err_cnt;
   modport master (output en, gray_in, clear_err,
                   input  bin_out, bin_valid, step_err, wrap, locked, err_cnt);
   modport slave  (input  en, gray_in, clear_err,
                   output bin_out, bin_valid, step_err, wrap, locked, err_cnt);
endinterface

// File: rtl/gray_count_decoder.sv
// gray_count_decoder: 2-stage Gray-to-binary decoder with step checking, wrap detect,
// lock FSM and saturating error counter.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : en/gray_in/clear_err in; bin_out/bin_valid/step_err/wrap/locked/err_cnt out
module gray_count_decoder #(
   parameter int SIZE       = 16,
   parameter int ERR_W      = 8,
   parameter int RESYNC_CNT = 2
) (
   input logic                  clk,
   input logic                  reset,
   gray_count_decoder_if.slave  bus
);
   localparam int W  = $clog2(SIZE);
   localparam int CW = $clog2(RESYNC_CNT + 1);
   localparam logic [W:0] SZ = (W+1)'(SIZE);

   typedef enum logic [1:0] {IDLE, TRACK, RESYNC} state_t;

   state_t           r_state, w_state_nx;
   logic [W-1:0]     w_b1, r_b1, r_prev, r_bin;
   logic             r_v1, r_valid, r_step_err, r_wrap;
   logic [CW-1:0]    r_good, w_good_nx;
   logic [ERR_W-1:0] r_err_cnt;
   logic [W:0]       w_delta;
   logic             w_inr, w_legal, w_err, w_wrap, w_err_evt;

   // bit i of the binary value is the XOR of all Gray bits at or above i
   always_comb
      for (int i = 0; i < W; i++) w_b1[i] = ^(bus.gray_in >> i);

   // modular distance from the last accepted value, kept in W+1 bits so SIZE fits
   assign w_inr     = {1'b0, r_b1} < SZ;
   assign w_delta   = (r_b1 >= r_prev) ? {1'b0, r_b1} - {1'b0, r_prev}
                                       : {1'b0, r_b1} + SZ - {1'b0, r_prev};
   assign w_legal   = w_inr && w_delta <= (W+1)'(1);
   assign w_err     = (r_state == IDLE) ? !w_inr : !w_legal;
   assign w_wrap    = r_state != IDLE && r_prev == W'(SIZE - 1) && r_b1 == '0;
   assign w_err_evt = r_v1 && w_err;

   always_comb begin
      w_state_nx = r_state;
      w_good_nx  = r_good;
      if (r_v1) begin
         if (r_state == IDLE)
            w_state_nx = w_inr ? TRACK : IDLE;
         else if (w_err) begin
            w_state_nx = RESYNC;
            w_good_nx  = '0;
         end else if (r_state == RESYNC) begin
            w_state_nx = (r_good + 1'b1 == CW'(RESYNC_CNT)) ? TRACK : RESYNC;
            w_good_nx  = (r_good + 1'b1 == CW'(RESYNC_CNT)) ? '0 : r_good + 1'b1;
         end
      end
   end

   always_ff @(posedge clk)
      if (reset) begin
         r_state <= IDLE;
         r_good  <= '0;
      end else begin
         r_state <= w_state_nx;
         r_good  <= w_good_nx;
      end

   always_ff @(posedge clk)
      if (reset) begin
         r_v1       <= 1'b0;
         r_b1       <= '0;
         r_valid    <= 1'b0;
         r_bin      <= '0;
         r_step_err <= 1'b0;
         r_wrap     <= 1'b0;
         r_prev     <= '0;
         r_err_cnt  <= '0;
      end else begin
         r_v1       <= bus.en;
         if (bus.en) r_b1 <= w_b1;
         r_valid    <= r_v1;
         r_step_err <= w_err_evt;
         r_wrap     <= r_v1 && w_wrap;
         if (r_v1) r_bin <= r_b1;
         // out-of-range values never become the reference for the next step
         if (r_v1 && w_inr) r_prev <= r_b1;
         r_err_cnt  <= bus.clear_err ? ERR_W'(w_err_evt)
                     : (w_err_evt && r_err_cnt != '1) ? r_err_cnt + 1'b1 : r_err_cnt;
      end

   assign bus.bin_out   = r_bin;
   assign bus.bin_valid = r_valid;
   assign bus.step_err  = r_step_err;
   assign bus.wrap      = r_wrap;
   assign bus.locked    = r_state == TRACK;
   assign bus.err_cnt   = r_err_cnt;
endmodule
